rf_wr_arbiter: RTL and testbench

Shares the register file's single write port between the pipeline writeback stage and a long-latency unit (LLU, e.g. a multi-cycle divider). LLU results are buffered in a small FIFO. A starvation counter guarantees LLU forward progress by stalling writeback. The block sits between WB/LLU and the register file; its rf_* outputs drive the register file's WE/rsw/dataW pins directly.

---
 rtl/rf_arb_pkg.sv | 17 +
 rtl/rf_arb_fifo.sv | 79 +++++++
 rtl/rf_wr_arbiter.sv | 152 +++++++++++++++
 tb/tb_rf_wr_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package rf_arb_pkg;

    localparam int REG_AW   = 5;
    localparam int XLEN_DEF = 32;

    typedef enum logic {
        NORMAL = 1'b0,
        STARVE = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic [REG_AW-1:0]   rd;
        logic [XLEN_DEF-1:0] data;
    } llu_entry_t;

endpackage

// File: rtl/rf_arb_fifo.sv
// Small synchronous FIFO for buffered LLU results, with a probe that reports
// whether a given destination register is held in any occupied slot.
module rf_arb_fifo
    import rf_arb_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = llu_entry_t
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    output entry_t                   head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [REG_AW-1:0]        probe_rd,
    output logic                     probe_hit
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [DEPTH-1:0] hit_vec;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: occupancy alone decides which slots are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_probe
            logic [AW-1:0] off;
            assign off         = AW'(gi) - rd_ptr_q;
            assign hit_vec[gi] = (CW'(off) < count_q) && (mem_q[gi].rd == probe_rd);
        end
    endgenerate

    assign head      = mem_q[rd_ptr_q];
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign probe_hit = |hit_vec;

endmodule

// File: rtl/rf_wr_arbiter.sv
// Register-file write-port arbiter between writeback and a long-latency unit.
// Optional perf counters are enabled with `define RF_ARB_PERF_EN.
module rf_wr_arbiter
    import rf_arb_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wb_we,
    input  logic [REG_AW-1:0]      wb_rd,
    input  logic [XLEN-1:0]        wb_data,
    output logic                   wb_stall,
    input  logic                   llu_valid,
    input  logic [REG_AW-1:0]      llu_rd,
    input  logic [XLEN-1:0]        llu_data,
    output logic                   llu_ready,
    output logic                   rf_we,
    output logic [REG_AW-1:0]      rf_rsw,
    output logic [XLEN-1:0]        rf_data,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] buf_count
`ifdef RF_ARB_PERF_EN
    ,
    output logic [31:0]            perf_conflict,
    output logic [31:0]            perf_stall
`endif
);

    localparam int WCW = $clog2(MAX_WAIT + 1);

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } entry_t;

    arb_state_e          state_q, state_d;
    logic [WCW-1:0]      wait_q, wait_d;
    entry_t              head, push_entry;
    logic                full, empty, waw_hit;
    logic [$clog2(DEPTH):0] count;
    logic                wb_req, grant_wb, grant_llu, stall_c, push;

    assign wb_req     = wb_we && (wb_rd != '0);
    assign push_entry = '{rd: llu_rd, data: llu_data};
    // x0 results finish the handshake but are dropped here.
    assign push       = rst && llu_valid && !full && (llu_rd != '0);

    rf_arb_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (grant_llu),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .probe_rd  (wb_rd),
        .probe_hit (waw_hit)
    );

    always_comb begin
        grant_wb  = 1'b0;
        grant_llu = 1'b0;
        stall_c   = 1'b0;
        state_d   = NORMAL;
        wait_d    = wait_q;
        if (rst) begin
            case (state_q)
                NORMAL: begin
                    if (wb_req) begin
                        grant_wb = 1'b1;
                    end else if (!empty) begin
                        grant_llu = 1'b1;
                    end
                end
                STARVE: begin
                    grant_llu = !empty;
                    stall_c   = wb_req;
                end
                default: ;
            endcase
            if (grant_llu) begin
                wait_d = '0;
            end else if (!empty) begin
                wait_d = WCW'(wait_q + 1'b1);
                if (wait_q == WCW'(MAX_WAIT - 1)) begin
                    state_d = STARVE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= NORMAL;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        rf_rsw  = '0;
        rf_data = '0;
        if (grant_wb) begin
            rf_rsw  = wb_rd;
            rf_data = wb_data;
        end else if (grant_llu) begin
            rf_rsw  = head.rd;
            rf_data = head.data;
        end
    end

    assign rf_we     = grant_wb || grant_llu;
    assign wb_stall  = stall_c;
    assign llu_ready = rst && !full;
    assign busy      = rst && !empty;
    assign buf_count = rst ? count : '0;

    // Simulation-only: the hazard unit must keep WB off any buffered destination.
    waw_excluded: assert property (@(posedge clk) disable iff (!rst) !(wb_req && waw_hit));

`ifdef RF_ARB_PERF_EN
    logic [31:0] perf_conflict_q, perf_stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_conflict_q <= '0;
            perf_stall_q    <= '0;
        end else begin
            if (grant_wb && !empty && (perf_conflict_q != '1)) begin
                perf_conflict_q <= perf_conflict_q + 1'b1;
            end
            if (stall_c && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 1'b1;
            end
        end
    end

    assign perf_conflict = perf_conflict_q;
    assign perf_stall    = perf_stall_q;
`endif

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Randomized bench for rf_wr_arbiter against a queue-based reference model.
module tb_rf_wr_arbiter;

    localparam int XLEN     = 32;
    localparam int DEPTH    = 2;
    localparam int MAX_WAIT = 4;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            wb_we = 1'b0;
    logic [4:0]      wb_rd = '0;
    logic [XLEN-1:0] wb_data = '0;
    logic            wb_stall;
    logic            llu_valid = 1'b0;
    logic [4:0]      llu_rd = '0;
    logic [XLEN-1:0] llu_data = '0;
    logic            llu_ready;
    logic            rf_we;
    logic [4:0]      rf_rsw;
    logic [XLEN-1:0] rf_data;
    logic            busy;
    logic [CW-1:0]   buf_count;
`ifdef RF_ARB_PERF_EN
    logic [31:0]     perf_conflict, perf_stall;
    int              m_conflict, m_stall;
`endif

    always #5 clk = ~clk;

    rf_wr_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .wb_we     (wb_we),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_stall  (wb_stall),
        .llu_valid (llu_valid),
        .llu_rd    (llu_rd),
        .llu_data  (llu_data),
        .llu_ready (llu_ready),
        .rf_we     (rf_we),
        .rf_rsw    (rf_rsw),
        .rf_data   (rf_data),
        .busy      (busy),
        .buf_count (buf_count)
`ifdef RF_ARB_PERF_EN
        ,
        .perf_conflict (perf_conflict),
        .perf_stall    (perf_stall)
`endif
    );

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t q[$];
    int   denied;
    int   n_vec, n_miss, cyc;
    bit   prev_stall, prev_blocked, last_xfer;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic set_in(input bit we, input int rd, input logic [31:0] d,
                          input bit lv, input int lrd, input logic [31:0] ld);
        wb_we = we; wb_rd = 5'(rd); wb_data = d;
        llu_valid = lv; llu_rd = 5'(lrd); llu_data = ld;
    endtask

    // Called just after a negedge with inputs applied; returns after the next negedge.
    task automatic step();
        bit wb_req, forced, g_wb, g_llu, stl, rdy;
        logic [4:0]      e_rsw;
        logic [XLEN-1:0] e_data;
        #1;
        if (!rst) begin
            q.delete();
            denied = 0;
`ifdef RF_ARB_PERF_EN
            m_conflict = 0;
            m_stall    = 0;
`endif
        end
        wb_req = wb_we && (wb_rd != 0);
        forced = (q.size() > 0) && (denied >= MAX_WAIT);
        g_wb   = rst && wb_req && !forced;
        g_llu  = rst && (q.size() > 0) && (forced || !wb_req);
        stl    = rst && wb_req && forced;
        rdy    = rst && (q.size() < DEPTH);
        e_rsw  = g_wb ? wb_rd : (g_llu ? q[0].rd : 5'd0);
        e_data = g_wb ? wb_data : (g_llu ? q[0].data : '0);
        check_val("rf_we", rf_we, g_wb || g_llu);
        check_val("rf_rsw", rf_rsw, e_rsw);
        check_val("rf_data", rf_data, e_data);
        check_val("wb_stall", wb_stall, stl);
        check_val("llu_ready", llu_ready, rdy);
        check_val("busy", busy, q.size() != 0);
        check_val("buf_count", buf_count, q.size());
`ifdef RF_ARB_PERF_EN
        check_val("perf_conflict", perf_conflict, m_conflict);
        check_val("perf_stall", perf_stall, m_stall);
`endif
        prev_stall   = stl;
        prev_blocked = llu_valid && !rdy;
        last_xfer    = llu_valid && rdy;
        @(posedge clk);
        if (rst) begin
`ifdef RF_ARB_PERF_EN
            if (g_wb && q.size() > 0) m_conflict++;
            if (stl) m_stall++;
`endif
            if (g_llu) begin
                void'(q.pop_front());
                denied = 0;
            end else if (q.size() > 0) begin
                denied++;
            end
            if (llu_valid && rdy && llu_rd != 0) q.push_back('{rd: llu_rd, data: llu_data});
        end
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        n_vec = 0; n_miss = 0; cyc = 0; denied = 0;
        #2 rst = 1'b0;
        @(negedge clk);

        // Reset held with a WB request pending, then first WB write
        set_in(1, 5, 32'hA5, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("t1_rst_we", rf_we, 0);
            check_val("t1_rst_rdy", llu_ready, 0);
            step();
        end
        rst = 1'b1;
        #1;
        check_val("t1_we", rf_we, 1);
        check_val("t1_rsw", rf_rsw, 5);
        check_val("t1_data", rf_data, 32'hA5);
        step();

        // LLU only
        set_in(0, 0, 0, 1, 7, 32'h1234);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        check_val("t2_busy", busy, 1);
        check_val("t2_cnt", buf_count, 1);
        check_val("t2_rsw", rf_rsw, 7);
        check_val("t2_data", rf_data, 32'h1234);
        step();
        #1;
        check_val("t2_busy0", busy, 0);
        check_val("t2_cnt0", buf_count, 0);
        step();

        // Fill FIFO under continuous WB; third result waits for a pop
        set_in(1, 3, 32'h30, 1, 17, 32'h17);
        step();
        set_in(1, 3, 32'h31, 1, 18, 32'h18);
        step();
        set_in(1, 3, 32'h32, 1, 19, 32'h19);
        #1;
        check_val("t3_full_rdy", llu_ready, 0);
        check_val("t3_full_cnt", buf_count, 2);
        for (int i = 0; i < 12; i++) begin
            step();
            if (last_xfer) break;
        end
        set_in(0, 0, 0, 0, 0, 0);
        repeat (3) step();

        // Starvation: one entry, WB every cycle
        set_in(1, 4, 32'h44, 1, 20, 32'hBEEF);
        step();
        set_in(1, 4, 32'h44, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_val("t4_wb_rsw", rf_rsw, 4);
            step();
        end
        #1;
        check_val("t4_stall", wb_stall, 1);
        check_val("t4_llu_rsw", rf_rsw, 20);
        check_val("t4_llu_data", rf_data, 32'hBEEF);
        step();
        #1;
        check_val("t4_again_rsw", rf_rsw, 4);
        check_val("t4_again_stall", wb_stall, 0);
        step();

        // x0 on both sides
        set_in(1, 0, 32'hDEAD, 1, 0, 32'hCAFE);
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("t5_we", rf_we, 0);
            check_val("t5_rdy", llu_ready, 1);
            step();
            #1;
            check_val("t5_cnt", buf_count, 0);
        end

        // Mid-operation reset with two entries buffered
        set_in(1, 2, 32'h22, 1, 21, 32'h21);
        step();
        set_in(1, 2, 32'h22, 1, 22, 32'h22);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        check_val("t6_pre_cnt", buf_count, 2);
        rst = 1'b0;
        #1;
        check_val("t6_cnt", buf_count, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_val("t6_no_stale", rf_we, 0);
`ifdef RF_ARB_PERF_EN
            check_val("t6_pc", perf_conflict, 0);
            check_val("t6_ps", perf_stall, 0);
`endif
            step();
        end

        // Randomized traffic; WB uses rd 0..15, LLU uses 0 or 16..31
        prev_stall = 0; prev_blocked = 0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) != 0);
            if (!prev_stall || !rst) begin
                wb_we   = ($urandom_range(0, 3) != 0);
                wb_rd   = 5'($urandom_range(0, 15));
                wb_data = $urandom;
            end
            if (!prev_blocked || !rst) begin
                llu_valid = ($urandom_range(0, 2) == 0);
                llu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
                llu_data  = $urandom;
            end
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
